// File: rtl/press_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : press_classifier
//  Description : Turns a debounced, active-high button level into one-cycle
//                gesture pulses: short press, long press and double press.
//                One FSM and one shared counter. The counter holds the length
//                of the current high run in PRESS1 and the length of the
//                current low run in WAIT2. All outputs are registered.
//
//  Parameters  : long_time     - consecutive high samples that make a long
//                                press (>= 2)
//                double_window - consecutive low samples after a short press
//                                that end the wait for a second press (>= 2)
//
//  Ports       : ck        in   system clock, rising edge
//                reset     in   synchronous, active-high reset
//                x         in   debounced button level, 1 = pressed
//                z_short   out  pulse: short press, no second press followed
//                z_long    out  pulse: press held for long_time samples
//                z_double  out  pulse: second press started inside the window
//
//  Revision    : 1.0  initial release
// ============================================================================
module press_classifier #(
    parameter int long_time     = 50,
    parameter int double_window = 20
) (
    input  logic ck,
    input  logic reset,
    input  logic x,
    output logic z_short,
    output logic z_long,
    output logic z_double
);

    localparam int c_max_time = (long_time > double_window) ? long_time : double_window;
    localparam int c_cnt_w    = $clog2(c_max_time) + 1;

    // Terminal counts. A counter value of N-1 at an edge that sees one more
    // qualifying sample means the N-th sample has just arrived.
    localparam logic [c_cnt_w-1:0] c_long_last   = c_cnt_w'(long_time - 1);
    localparam logic [c_cnt_w-1:0] c_window_last = c_cnt_w'(double_window - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS1 = 2'd1,
        WAIT2  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_next_cnt;
    logic                w_short;
    logic                w_long;
    logic                w_double;

    // State, counter and output registers.
    always_ff @(posedge ck) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            z_short  <= 1'b0;
            z_long   <= 1'b0;
            z_double <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            z_short  <= w_short;
            z_long   <= w_long;
            z_double <= w_double;
        end
    end

    // Next-state, next-count and event decode.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_short      = 1'b0;
        w_long       = 1'b0;
        w_double     = 1'b0;

        case (r_state)
            IDLE: begin
                if (x) begin
                    w_next_state = PRESS1;
                    w_next_cnt   = c_cnt_one;
                end
            end

            PRESS1: begin
                if (x) begin
                    if (r_cnt == c_long_last) begin
                        w_next_state = HOLD;
                        w_long       = 1'b1;
                    end else begin
                        w_next_cnt = r_cnt + c_cnt_one;
                    end
                end else begin
                    w_next_state = WAIT2;
                    w_next_cnt   = c_cnt_one;
                end
            end

            WAIT2: begin
                if (x) begin
                    // The second press is committed as a double on its first
                    // sample; its duration no longer matters, so it parks in
                    // HOLD until release.
                    w_next_state = HOLD;
                    w_double     = 1'b1;
                end else if (r_cnt == c_window_last) begin
                    w_next_state = IDLE;
                    w_short      = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + c_cnt_one;
                end
            end

            HOLD: begin
                // After a long or double event the press is consumed; a later
                // press starts a fresh sequence from IDLE.
                if (!x) begin
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_press_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_press_classifier
//  Description : Self-checking bench for press_classifier with long_time=4,
//                double_window=3 and a 20 ns clock. Directed gesture steps
//                followed by random high/low runs with occasional resets.
//                Expected pulses come from a sample-history model that
//                classifies the run pattern of the current sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_press_classifier;

    localparam int c_long_time     = 4;
    localparam int c_double_window = 3;

    logic ck;
    logic reset;
    logic x;
    logic z_short;
    logic z_long;
    logic z_double;

    int vectors;
    int miscompares;

    // Reference model state: mode 0 = no sequence, 1 = sequence in progress
    // (history held in hist), 2 = event already decided, waiting for release.
    int mode;
    bit hist[$];
    logic exp_short;
    logic exp_long;
    logic exp_double;

    press_classifier #(
        .long_time     (c_long_time),
        .double_window (c_double_window)
    ) dut (
        .ck       (ck),
        .reset    (reset),
        .x        (x),
        .z_short  (z_short),
        .z_long   (z_long),
        .z_double (z_double)
    );

    initial ck = 1'b0;
    always #10 ck = ~ck;

    // Classify the current sequence from its sample history:
    // leading ones (first press), then zeros (gap), then anything after.
    task automatic model_step(input logic xv, input logic rv);
        int h;
        int z;
        int rest;
        exp_short  = 1'b0;
        exp_long   = 1'b0;
        exp_double = 1'b0;
        if (rv) begin
            mode = 0;
            hist.delete();
        end else if (mode == 0) begin
            if (xv) begin
                mode = 1;
                hist.delete();
                hist.push_back(1'b1);
            end
        end else if (mode == 1) begin
            hist.push_back(xv);
            h = 0;
            while (h < hist.size() && hist[h]) h++;
            z = 0;
            while (h + z < hist.size() && !hist[h + z]) z++;
            rest = hist.size() - h - z;
            if (z == 0 && h == c_long_time) begin
                exp_long = 1'b1;
                mode     = 2;
            end else if (z > 0 && rest > 0) begin
                exp_double = 1'b1;
                mode       = 2;
            end else if (z == c_double_window) begin
                exp_short = 1'b1;
                mode      = 0;
            end
        end else begin
            if (!xv) mode = 0;
        end
    endtask

    // Drive one sample between edges, let the DUT take it, then check
    // the registered outputs 1 ns after the edge.
    task automatic step(input logic xv, input logic rv);
        @(negedge ck);
        x     = xv;
        reset = rv;
        @(posedge ck);
        model_step(xv, rv);
        #1;
        vectors++;
        assert (z_short === exp_short) else begin
            miscompares++;
            $error("FAIL z_short t=%0t observed=%b expected=%b", $time, z_short, exp_short);
        end
        vectors++;
        assert (z_long === exp_long) else begin
            miscompares++;
            $error("FAIL z_long t=%0t observed=%b expected=%b", $time, z_long, exp_long);
        end
        vectors++;
        assert (z_double === exp_double) else begin
            miscompares++;
            $error("FAIL z_double t=%0t observed=%b expected=%b", $time, z_double, exp_double);
        end
        vectors++;
        assert ($countones({z_short, z_long, z_double}) <= 1) else begin
            miscompares++;
            $error("FAIL onehot t=%0t observed=%b%b%b expected=at most one high",
                   $time, z_short, z_long, z_double);
        end
    endtask

    task automatic run(input logic xv, input int n);
        for (int i = 0; i < n; i++) step(xv, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mode        = 0;
        x           = 1'b0;
        reset       = 1'b1;

        // 1. Reset held 3 cycles with x low, outputs stay 0.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        run(1'b0, 3);
        // x high during reset counts as a new press at the first free edge:
        // 4 samples after release give a long pulse on the 4th.
        step(1'b1, 1'b1);
        run(1'b1, 5);
        run(1'b0, 4);

        // 2. Short press, 3 highs (one short of long), then 5 lows.
        run(1'b1, 3);
        run(1'b0, 5);

        // 3. Long press, 14 highs then low.
        run(1'b1, 14);
        run(1'b0, 5);

        // 4. Double press at the window boundary: 2 high, 2 low, 6 high.
        run(1'b1, 2);
        run(1'b0, 2);
        run(1'b1, 6);
        run(1'b0, 5);

        // 5. Window expiry: two separate short presses.
        run(1'b1, 2);
        run(1'b0, 3);
        run(1'b1, 2);
        run(1'b0, 3);
        run(1'b0, 2);

        // 6. Reset after one low sample in the wait window, then scenario 2.
        run(1'b1, 2);
        run(1'b0, 1);
        step(1'b0, 1'b1);
        run(1'b0, 6);
        run(1'b1, 3);
        run(1'b0, 5);

        // Long press followed quickly by another press: long, then a new
        // sequence, never a double.
        run(1'b1, 5);
        run(1'b0, 1);
        run(1'b1, 1);
        run(1'b0, 5);

        // Random runs with occasional resets.
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 19) == 0) begin
                step(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                run(1'(r % 2 == 0), int'($urandom_range(1, 7)));
            end
        end
        run(1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/press_classifier.md
# press_classifier

Classifies a debounced, active-high push-button level into three gesture events: short press, long press and double press. Each event is a one-cycle pulse. The block sits directly downstream of `debouncer`: its `x` input is the debouncer's `z` output. It replaces ad-hoc edge detection on button paths that need gesture semantics.

## Interface

Parameters:
- `long_time`, default 50: number of consecutive high samples of `x` that make a long press. Must be ≥ 2.
- `double_window`, default 20: number of consecutive low samples after a short press that end the wait for a second press. Must be ≥ 2.

Ports:
- `ck`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `x`  input  1  debounced button level, 1 = pressed; already synchronous to `ck`.
- `z_short`  output  1  one-cycle pulse: short press, no second press followed.
- `z_long`  output  1  one-cycle pulse: press held for `long_time` samples.
- `z_double`  output  1  one-cycle pulse: second press started within the window.

## Operation

- Single FSM with a shared counter `cnt`. Counter width is $clog2(max(long_time, double_window)) + 1. The counter never exceeds max(long_time, double_window).
- States and transitions. Each is evaluated at a rising edge of `ck`, using the sampled `x`.
  - IDLE:
    - x=1: go to PRESS1, cnt←1.
    - Otherwise stay in IDLE.
  - PRESS1:
    - x=1 and cnt==long_time−1: go to HOLD and pulse `z_long`.
    - x=1 otherwise: cnt←cnt+1.
    - x=0: go to WAIT2, cnt←1.
  - WAIT2:
    - x=1: go to HOLD and pulse `z_double`.
    - x=0 and cnt==double_window−1: go to IDLE and pulse `z_short`.
    - x=0 otherwise: cnt←cnt+1.
  - HOLD:
    - x=0: go to IDLE.
    - Otherwise stay in HOLD. No events are produced in HOLD.
- At most one of `z_short`, `z_long`, `z_double` is high in any cycle. Each gesture produces exactly one pulse.
- A long press followed by a quick press is a long event, then a new sequence starting from IDLE. It is never a double.
- Reset, including mid-operation:
  - State returns to IDLE, cnt←0, all outputs 0.
  - A pending short or double is discarded and no pulse is emitted.
  - If `x` is still 1 at the first edge after `reset` falls, it is treated as a new press (IDLE→PRESS1).

## Timing

- All outputs are registered. A pulse is high for exactly one `ck` period, starting at the edge that decides the event.
- Reset value of every output is 0. State after reset is IDLE.
- `z_long` latency: asserted at the edge of the `long_time`-th consecutive high sample, i.e. `long_time`−1 cycles after the PRESS1 entry edge.
- `z_short` latency: asserted at the edge of the `double_window`-th consecutive low sample after release.
- `z_double` latency: asserted at the first high sample in WAIT2.
- A press of exactly `long_time`−1 high samples is short, not long.
- A gap of exactly `double_window`−1 low samples followed by a high sample is a double.
- No input registering inside the block. The debouncer output is assumed glitch-free and synchronous.

## Test plan

All scenarios use `long_time`=4, `double_window`=3, a 20 ns clock, and `x` changing between edges.

1. Reset held 3 cycles with x=0, then released:
   - all outputs 0 throughout, state IDLE.
   - x=1 held during reset gives PRESS1 at the first post-reset edge.
2. Short press, boundary case:
   - x=1 for 3 samples (e0–e2), then x=0 for 5 samples.
   - `z_short`=1 only between e5 and e6.
   - `z_long` and `z_double` stay 0.
3. Long press:
   - x=1 for 14 samples, then 0.
   - `z_long`=1 only in the cycle after the 4th high sample edge (e3).
   - No pulse during the hold or after release.
4. Double press, window boundary:
   - x=1 for 2 samples, 0 for 2 samples, then 1 for 6 samples.
   - `z_double`=1 at the first high sample of the second press.
   - No `z_short` and no `z_long`, even though the second press lasts 6 samples.
5. Window expiry:
   - x=1 for 2 samples, 0 for 3 samples, then 1 for 2 samples, then 0 for 3 samples.
   - Two separate `z_short` pulses, and no `z_double`.
6. Reset mid-gesture:
   - `reset` pulsed while in WAIT2 (after 1 low sample).
   - No `z_short` is emitted afterward and all outputs stay 0.
   - Scenario 2 repeated after reset behaves identically.
